// File: rtl/ta_fifo_writebuf.sv
// Write buffer from SH4 64-bit stores in the TA FIFO region to the 32-bit TA parameter parser.
// Entries drain low word first; every 8 words form one 32-byte block marked by sop/eop.
module ta_fifo_writebuf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ta_fifo_cs,
  input  logic          wr_valid,
  input  logic [63:0]   wr_data,
  output logic          wr_ready,
  input  logic          flush,
  output logic [31:0]   ta_data,
  output logic          ta_valid,
  input  logic          ta_ready,
  output logic          ta_sop,
  output logic          ta_eop,
  output logic [AW:0]   level,
  output logic          ovf_err,
  input  logic          err_clr
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [AW:0]   level_next;
  logic          half_reg;
  logic [2:0]    wcnt_reg;
  logic          ovf_reg;
  logic [63:0]   head;
  logic          push;
  logic          drop;
  logic          pop;
  logic          free;

  assign wr_ready = (level_reg != LVL_FULL);
  assign ta_valid = (level_reg != '0);
  assign level    = level_reg;
  assign ovf_err  = ovf_reg;

  assign head    = mem[rd_ptr_reg];
  assign ta_data = ta_valid ? (half_reg ? head[63:32] : head[31:0]) : 32'd0;
  assign ta_sop  = ta_valid & (wcnt_reg == 3'd0);
  assign ta_eop  = ta_valid & (wcnt_reg == 3'd7);

  // A store coinciding with flush is neither written nor counted as an overflow.
  assign push = ta_fifo_cs & wr_valid & wr_ready & ~flush;
  assign drop = ta_fifo_cs & wr_valid & ~wr_ready & ~flush;
  assign pop  = ta_valid & ta_ready;
  assign free = pop & half_reg;

  always_comb begin
    level_next = level_reg;
    case ({push, free})
      2'b10:   level_next = level_reg + LVL_ONE;
      2'b01:   level_next = level_reg - LVL_ONE;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      half_reg   <= 1'b0;
      wcnt_reg   <= 3'd0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      half_reg   <= 1'b0;
      wcnt_reg   <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        half_reg <= ~half_reg;
        wcnt_reg <= wcnt_reg + 3'd1;
      end
      if (free) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      level_reg <= level_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_reg <= 1'b0;
    end else if (err_clr) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ta_fifo_writebuf.sv
// Directed bench for ta_fifo_writebuf: block framing, back-pressure, fill/overflow,
// random concurrency against a word scoreboard, flush and asynchronous reset.
module tb_ta_fifo_writebuf;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ta_fifo_cs = 1'b0;
  logic        wr_valid = 1'b0;
  logic [63:0] wr_data = '0;
  logic        flush = 1'b0;
  logic        ta_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        wr_ready;
  logic [31:0] ta_data;
  logic        ta_valid;
  logic        ta_sop;
  logic        ta_eop;
  logic [6:0]  level;
  logic        ovf_err;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  int          lvl = 0;
  bit          half = 1'b0;
  int          w = 0;
  bit          ovf = 1'b0;

  ta_fifo_writebuf #(.DEPTH(64), .AW(6)) dut (
    .clock(clock), .reset_n(reset_n), .ta_fifo_cs(ta_fifo_cs), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .flush(flush), .ta_data(ta_data),
    .ta_valid(ta_valid), .ta_ready(ta_ready), .ta_sop(ta_sop), .ta_eop(ta_eop),
    .level(level), .ovf_err(ovf_err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    lvl  = 0;
    half = 1'b0;
    w    = 0;
  endtask

  // One clock: check outputs against the model, apply inputs, advance the model.
  task automatic cyc(input logic v, input logic [63:0] d, input logic r);
    bit full;
    ta_fifo_cs = 1'b1;
    wr_valid   = v;
    wr_data    = d;
    ta_ready   = r;
    full = (lvl == 64);
    chk("level", 64'(level), 64'(lvl));
    chk("wr_ready", 64'(wr_ready), 64'(!full));
    chk("ta_valid", 64'(ta_valid), 64'(lvl != 0));
    chk("ovf_err", 64'(ovf_err), 64'(ovf));
    if (lvl != 0) begin
      chk("ta_data", 64'(ta_data), 64'(exp_q[0]));
      chk("ta_sop", 64'(ta_sop), 64'(w == 0));
      chk("ta_eop", 64'(ta_eop), 64'(w == 7));
    end else begin
      chk("sop_idle", 64'(ta_sop), 64'd0);
    end
    if (lvl != 0 && r) begin
      void'(exp_q.pop_front());
      if (half) lvl--;
      half = !half;
      w = (w + 1) % 8;
    end
    if (v && !full) begin
      exp_q.push_back(d[31:0]);
      exp_q.push_back(d[63:32]);
      lvl++;
    end
    if (err_clr) ovf = 1'b0;
    else if (v && full) ovf = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    int stores;
    int cycles;
    logic rv;
    logic rr;

    // Reset state
    #12;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_ta_valid", 64'(ta_valid), 64'd0);
    chk("rst_sop", 64'(ta_sop), 64'd0);
    chk("rst_eop", 64'(ta_eop), 64'd0);
    chk("rst_data", 64'(ta_data), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Store outside the TA FIFO region is ignored
    ta_fifo_cs = 1'b0;
    wr_valid   = 1'b1;
    wr_data    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    wr_valid = 1'b0;
    chk("cs0_level", 64'(level), 64'd0);

    // T1: single block
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, {32'h1111_1111 * (2 * i + 1), 32'h1111_1111 * (2 * i)}, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      chk("t1_word", 64'(ta_data), 64'(32'h1111_1111 * k));
      cyc(1'b0, 64'd0, 1'b1);
    end
    cyc(1'b0, 64'd0, 1'b0);

    // T2: back-pressure holds the head word
    cyc(1'b1, 64'h1111_1111_0000_0000, 1'b0);
    cyc(1'b1, 64'h3333_3333_2222_2222, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_data", 64'(ta_data), 64'h0);
      chk("t2_hold_sop", 64'(ta_sop), 64'd1);
      chk("t2_hold_level", 64'(level), 64'd2);
      cyc(1'b0, 64'd0, 1'b0);
    end
    cyc(1'b1, 64'h5555_5555_4444_4444, 1'b0);
    cyc(1'b1, 64'h7777_7777_6666_6666, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 64'd0, 1'b1);

    // T3: fill, overflow, clear, drain
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, {32'hC000_0000 + 32'(2 * i + 1), 32'hC000_0000 + 32'(2 * i)}, 1'b0);
    end
    chk("t3_full_level", 64'(level), 64'd64);
    chk("t3_full_ready", 64'(wr_ready), 64'd0);
    cyc(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    chk("t3_ovf_set", 64'(ovf_err), 64'd1);
    err_clr = 1'b1;
    cyc(1'b0, 64'd0, 1'b0);
    err_clr = 1'b0;
    chk("t3_ovf_clr", 64'(ovf_err), 64'd0);
    for (int i = 0; i < 128; i++) cyc(1'b0, 64'd0, 1'b1);
    chk("t3_empty", 64'(ta_valid), 64'd0);

    // T4: random stores with random parser readiness
    stores = 0;
    cycles = 0;
    while (stores < 200 && cycles < 5000) begin
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      if (rv && lvl != 64) stores++;
      cyc(rv, {$urandom(), $urandom()}, rr);
      cycles++;
    end
    while (lvl != 0 && cycles < 6000) begin
      cyc(1'b0, 64'd0, 1'($urandom_range(0, 1)));
      cycles++;
    end
    if (lvl != 0 || stores < 200) begin
      total++;
      bad++;
      $error("FAIL t4_timeout observed stores=%0d level=%0d required stores=200 level=0", stores, lvl);
    end
    err_clr = 1'b1;
    cyc(1'b0, 64'd0, 1'b0);
    err_clr = 1'b0;

    // T5: flush mid-block, with a store in the flush cycle
    cyc(1'b1, 64'h0000_0002_0000_0001, 1'b0);
    cyc(1'b1, 64'h0000_0004_0000_0003, 1'b0);
    cyc(1'b1, 64'h0000_0006_0000_0005, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 64'd0, 1'b1);
    flush      = 1'b1;
    ta_fifo_cs = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = 64'h9999_9999_9999_9999;
    ta_ready   = 1'b1;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    model_clear();
    chk("t5_level", 64'(level), 64'd0);
    chk("t5_valid", 64'(ta_valid), 64'd0);
    cyc(1'b0, 64'd0, 1'b0);
    cyc(1'b1, 64'h0000_AAAA_0000_BBBB, 1'b0);
    chk("t5_word", 64'(ta_data), 64'h0000_BBBB);
    chk("t5_sop", 64'(ta_sop), 64'd1);
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b0, 64'd0, 1'b1);

    // T6: asynchronous reset between clock edges
    for (int i = 0; i < 5; i++) cyc(1'b1, {32'hE000_0000, 32'(i)}, 1'b0);
    chk("t6_level5", 64'(level), 64'd5);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_valid", 64'(ta_valid), 64'd0);
    chk("t6_wr_ready", 64'(wr_ready), 64'd1);
    model_clear();
    ovf = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    cyc(1'b1, 64'h1234_5678_8765_4321, 1'b0);
    chk("t6_sop", 64'(ta_sop), 64'd1);
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b0, 64'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
